// File: rtl/fwrisc_mds_issue.sv
// fwrisc_mds_issue: single-outstanding issue/response sequencer in front of the MDS unit.
// Define FWRISC_MDS_ISSUE_TIMEOUT_EN to build the WAIT/DRAIN watchdog.
module fwrisc_mds_issue #(
  parameter int unsigned TIMEOUT_CYC = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic [31:0] mds_in_a,
  output logic [31:0] mds_in_b,
  output logic [3:0]  mds_op,
  output logic        mds_in_valid,
  input  logic [31:0] mds_out,
  input  logic        mds_out_valid,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    RESP   = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  localparam logic [5:0] TIMEOUT_LIM = 6'(TIMEOUT_CYC);

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic        accept;
  logic        op_legal;
  logic        expired;

  assign op_legal = (req_op <= 4'd8);

  // A flush in RESP wins over the handshake, so no new request may slip in with it.
  always_comb begin
    req_ready = 1'b0;
    if (rst) begin
      if (state_q == IDLE)
        req_ready = 1'b1;
      else if ((state_q == RESP) && rsp_ready && !flush)
        req_ready = 1'b1;
    end
  end

  assign accept       = req_valid && req_ready;
  assign mds_in_valid = rst && (state_q == LAUNCH);
  assign rsp_valid    = rst && (state_q == RESP);
  assign busy         = rst && (state_q != IDLE);
  assign mds_in_a     = a_q;
  assign mds_in_b     = b_q;
  assign mds_op       = op_q;
  assign rsp_data     = data_q;
  assign rsp_rd       = rd_q;
  assign rsp_err      = err_q;

`ifdef FWRISC_MDS_ISSUE_TIMEOUT_EN
  logic [5:0] cnt_q, cnt_d;

  assign expired = (cnt_q == TIMEOUT_LIM);

  always_comb begin
    cnt_d = cnt_q;
    if ((state_d == WAIT) || (state_d == DRAIN)) begin
      if (state_d != state_q)
        cnt_d = 6'd0;
      else
        cnt_d = cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      cnt_q <= 6'd0;
    else
      cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;

  assign expired        = 1'b0;
  assign unused_timeout = ^TIMEOUT_LIM;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    data_d  = data_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      LAUNCH: begin
        state_d = flush ? DRAIN : WAIT;
      end
      WAIT: begin
        // A result arriving with the flush leaves nothing in flight, so skip DRAIN.
        if (flush) begin
          state_d = mds_out_valid ? IDLE : DRAIN;
        end else if (mds_out_valid) begin
          data_d  = mds_out;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (expired) begin
          data_d  = 32'hFFFF_FFFF;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (flush || rsp_ready)
          state_d = IDLE;
      end
      DRAIN: begin
        if (mds_out_valid || expired)
          state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      op_d = req_op;
      a_d  = req_a;
      b_d  = req_b;
      rd_d = req_rd;
      if (op_legal) begin
        state_d = LAUNCH;
      end else begin
        data_d  = 32'h0;
        err_d   = 1'b1;
        state_d = RESP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= 4'd0;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      rd_q    <= 5'd0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/fwrisc_mds_issue.md
FWRISC_MDS_ISSUE -- requirements
Module: fwrisc_mds_issue

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 63, maximum cycles spent in WAIT before the watchdog fires (Configuration).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 req_valid  in  1  upstream request valid.
REQ-005 req_ready  out  1  block accepts request this cycle.
REQ-006 req_op  in  4  MDS opcode: 0 SLL, 1 SRL, 2 SRA, 3 MUL, 4 MULH, 5 MULS, 6 MULSH, 7 DIV, 8 REM.
REQ-007 req_a, req_b  in  32 each  operands.
REQ-008 req_rd  in  5  destination-register tag, returned unchanged with the response.
REQ-009 flush  in  1  abort the in-flight operation; no response is produced.
REQ-010 mds_in_a, mds_in_b  out  32 each  operands to the downstream mul/div/shift unit.
REQ-011 mds_op  out  4  opcode to the unit.
REQ-012 mds_in_valid  out  1  one-cycle launch pulse.
REQ-013 mds_out  in  32  unit result.
REQ-014 mds_out_valid  in  1  unit result valid; single-cycle pulse.
REQ-015 rsp_valid  out  1  response valid.
REQ-016 rsp_ready  in  1  downstream accepts response.
REQ-017 rsp_data  out  32  result.
REQ-018 rsp_rd  out  5  tag.
REQ-019 rsp_err  out  1  illegal opcode or timeout.
REQ-020 busy  out  1  high in any state other than IDLE.

Function
REQ-021 The FSM SHALL have the states IDLE, LAUNCH, WAIT, RESP and DRAIN.
REQ-022 req_ready SHALL be 1 in IDLE, and in RESP when rsp_ready=1 in the same cycle (back-to-back); it SHALL be 0 otherwise.
REQ-023 On accept, the block SHALL register op/a/b/rd; a legal op (0-8) goes to LAUNCH, an illegal op (9-15) goes to RESP with rsp_data=0, rsp_err=1, and no launch.
REQ-024 In LAUNCH, mds_in_valid SHALL be 1 for exactly one cycle with the registered operands, then the FSM goes to WAIT; mds_in_valid SHALL be 0 in every other state.
REQ-025 mds_in_a/b/op SHALL hold the registered values from LAUNCH until the next accept.
REQ-026 In WAIT, on mds_out_valid=1 the block SHALL capture mds_out into rsp_data, set rsp_err=0, and go to RESP; mds_out_valid seen in any state except WAIT or DRAIN SHALL be ignored.
REQ-027 In RESP, rsp_valid SHALL be 1 and rsp_data/rsp_rd/rsp_err SHALL stay stable until rsp_valid&&rsp_ready.
REQ-028 On response handshake, the FSM SHALL go to IDLE, or to LAUNCH/RESP if a new request is accepted in the same cycle.
REQ-029 Minimum latency SHALL be accept at edge N, launch during N+1, response valid the cycle after mds_out_valid.
REQ-030 flush in LAUNCH or WAIT SHALL go to DRAIN, and in LAUNCH the pulse SHALL still be issued.
REQ-031 DRAIN SHALL discard the next mds_out_valid and then go to IDLE.
REQ-032 flush in IDLE SHALL have no effect.
REQ-033 flush in RESP SHALL drop the response and go to IDLE.
REQ-034 flush SHALL take priority over mds_out_valid and over the response handshake in the same cycle.
REQ-035 The block SHALL hold at most one outstanding operation.

Reset
REQ-036 While rst=0, the FSM SHALL be IDLE, and rsp_valid, mds_in_valid, rsp_err and busy SHALL be 0.
REQ-037 While rst=0, rsp_data, mds_in_a, mds_in_b SHALL be 32'h0, and rsp_rd and mds_op SHALL be 0.
REQ-038 While rst=0, req_ready SHALL be 0; it SHALL be 1 in the first cycle after rst rises.
REQ-039 Reset mid-operation SHALL abandon the operation with no response; the downstream unit is reset by the same system reset.

Configuration
REQ-040 Macro FWRISC_MDS_ISSUE_TIMEOUT_EN SHALL control the watchdog.
REQ-041 With FWRISC_MDS_ISSUE_TIMEOUT_EN defined, a 6-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-042 With the watchdog, when the counter equals TIMEOUT_CYC without mds_out_valid, the FSM SHALL go to RESP with rsp_data=32'hFFFF_FFFF and rsp_err=1.
REQ-043 With the watchdog, the same counter SHALL bound DRAIN, with a timeout there going to IDLE.
REQ-044 With FWRISC_MDS_ISSUE_TIMEOUT_EN undefined, there SHALL be no counter, WAIT/DRAIN SHALL wait indefinitely, and rsp_err SHALL be set only for illegal ops.

Verification
REQ-045 SLL a=1 b=4 rd=3, unit model returns 16 -> one mds_in_valid pulse, rsp_data=16, rsp_rd=3, rsp_err=0.
REQ-046 MUL a=3 b=5, rsp_ready held 0 for 5 cycles -> rsp_valid held, rsp_data=15 stable, req_ready=0 throughout.
REQ-047 op=4'hC rd=7 -> rsp_valid the cycle after accept, rsp_data=0, rsp_err=1, mds_in_valid never asserted.
REQ-048 DIV 100/7, flush in WAIT, then a new SRL request -> no response for the DIV, next mds_out_valid discarded, SRL response correct.
REQ-049 Two back-to-back requests with rsp_ready=1 -> second accepted in the response cycle, second launch the next cycle, no bubble.
REQ-050 With FWRISC_MDS_ISSUE_TIMEOUT_EN, the unit model never responds -> after 63 WAIT cycles rsp_data=32'hFFFF_FFFF, rsp_err=1.
